// File: rtl/dcache_pkg.sv
// +-----------------------------------------------------------------------+
// | dcache_pkg: shared types and geometry helpers for the data cache      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package dcache_pkg;

    localparam int WORD_ADDR_W = 30;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_DATA = 3'd2,
        RESPOND     = 3'd3,
        WRITE_REQ   = 3'd4
    } state_t;

    // Fields are sized for the widest geometry; callers keep the low bits they need.
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] tag;
        logic [WORD_ADDR_W-1:0] index;
        logic [WORD_ADDR_W-1:0] offset;
    } addr_split_t;

    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines, input int words_per_line);
        return WORD_ADDR_W - offset_width(words_per_line) - index_width(lines);
    endfunction

    function automatic addr_split_t split_addr(input logic [WORD_ADDR_W-1:0] word_addr,
                                               input int offset_w, input int index_w);
        addr_split_t s;
        s.offset = word_addr & ((30'd1 << offset_w) - 30'd1);
        s.index  = (word_addr >> offset_w) & ((30'd1 << index_w) - 30'd1);
        s.tag    = word_addr >> (offset_w + index_w);
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_data_ram.sv
// +-----------------------------------------------------------------------+
// | dcache_data_ram: word array, byte-enabled sync write, comb read       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dcache_data_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// +-----------------------------------------------------------------------+
// | dcache_controller: direct-mapped write-through no-allocate D-cache    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Req,
    input  logic        i_Write,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_WriteData,
    input  logic [3:0]  i_ByteEnable,
    output logic        o_Stall,
    output logic        o_ReadValid,
    output logic [31:0] o_ReadData,
    output logic        o_MemReq,
    output logic        o_MemWrite,
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWriteData,
    output logic [3:0]  o_MemByteEnable,
    input  logic        i_MemReady,
    input  logic        i_MemReadValid,
    input  logic [31:0] i_MemReadData
);

    localparam int OFFSET_W = offset_width(WORDS_PER_LINE);
    localparam int INDEX_W  = index_width(LINES);
    localparam int TAG_W    = tag_width(LINES, WORDS_PER_LINE);
    localparam int RAM_AW   = OFFSET_W + INDEX_W;

    state_t state, state_next;

    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem [LINES];
    logic [TAG_W-1:0]    lat_tag;
    logic [INDEX_W-1:0]  lat_index;
    logic [OFFSET_W-1:0] lat_offset;
    logic [31:0]         lat_wdata;
    logic [3:0]          lat_be;
    logic [OFFSET_W-1:0] beat_cnt;
    logic                read_valid;
    logic [31:0]         read_data;

    addr_split_t         req_split;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                hit;
    logic                unused_bits;

    logic                load_hit, load_miss, store_start, load_done;
    logic                refill_accept, refill_beat, last_beat;

    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr, ram_raddr;
    logic [31:0]         ram_wdata, ram_rdata;
    logic [3:0]          ram_wbe;

    assign req_split  = split_addr(i_Addr[31:2], OFFSET_W, INDEX_W);
    assign req_tag    = req_split.tag[TAG_W-1:0];
    assign req_index  = req_split.index[INDEX_W-1:0];
    assign req_offset = req_split.offset[OFFSET_W-1:0];
    assign unused_bits = ^{i_Addr[1:0], req_split.tag[WORD_ADDR_W-1:TAG_W],
                           req_split.index[WORD_ADDR_W-1:INDEX_W],
                           req_split.offset[WORD_ADDR_W-1:OFFSET_W]};

    assign hit           = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign load_hit      = (state == IDLE) && i_Req && !i_Write && hit;
    assign load_miss     = (state == IDLE) && i_Req && !i_Write && !hit;
    assign store_start   = (state == IDLE) && i_Req && i_Write;
    assign load_done     = load_hit || (state == RESPOND);
    assign refill_accept = (state == REFILL_REQ) && i_MemReady;
    assign refill_beat   = (state == REFILL_DATA) && i_MemReadValid;
    assign last_beat     = refill_beat && (beat_cnt == OFFSET_W'(WORDS_PER_LINE - 1));

    assign o_ReadValid = read_valid;
    assign o_ReadData  = read_data;

    always_comb begin
        state_next      = state;
        o_Stall         = 1'b0;
        o_MemReq        = 1'b0;
        o_MemWrite      = 1'b0;
        o_MemAddr       = '0;
        o_MemWriteData  = '0;
        o_MemByteEnable = '0;
        ram_we          = 1'b0;
        ram_waddr       = {req_index, req_offset};
        ram_wdata       = i_WriteData;
        ram_wbe         = i_ByteEnable;
        ram_raddr       = {req_index, req_offset};
        case (state)
            IDLE: begin
                if (i_Req) begin
                    if (i_Write) begin
                        o_Stall    = 1'b1;
                        state_next = WRITE_REQ;
                        // Merge happens only here, so waiting in WRITE_REQ cannot re-merge.
                        ram_we     = hit;
                    end else if (!hit) begin
                        o_Stall    = 1'b1;
                        state_next = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                o_Stall   = 1'b1;
                o_MemReq  = 1'b1;
                o_MemAddr = {lat_tag, lat_index, {OFFSET_W{1'b0}}, 2'b00};
                if (i_MemReady) begin
                    state_next = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                o_Stall   = 1'b1;
                ram_we    = i_MemReadValid;
                ram_waddr = {lat_index, beat_cnt};
                ram_wdata = i_MemReadData;
                ram_wbe   = 4'hF;
                if (last_beat) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                ram_raddr  = {lat_index, lat_offset};
                state_next = IDLE;
            end
            WRITE_REQ: begin
                o_MemReq        = 1'b1;
                o_MemWrite      = 1'b1;
                o_MemAddr       = {lat_tag, lat_index, lat_offset, 2'b00};
                o_MemWriteData  = lat_wdata;
                o_MemByteEnable = lat_be;
                o_Stall         = !i_MemReady;
                if (i_MemReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state      <= IDLE;
            valid      <= '0;
            beat_cnt   <= '0;
            lat_tag    <= '0;
            lat_index  <= '0;
            lat_offset <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            state      <= state_next;
            read_valid <= load_done;
            if (load_done) begin
                read_data <= ram_rdata;
            end
            if (load_miss || store_start) begin
                lat_tag    <= req_tag;
                lat_index  <= req_index;
                lat_offset <= req_offset;
            end
            if (store_start) begin
                lat_wdata <= i_WriteData;
                lat_be    <= i_ByteEnable;
            end
            // Invalidate up front so an aborted refill never leaves a valid partial line.
            if (load_miss) begin
                valid[req_index] <= 1'b0;
            end
            if (last_beat) begin
                valid[lat_index] <= 1'b1;
            end
            if (refill_accept) begin
                beat_cnt <= '0;
            end else if (refill_beat) begin
                beat_cnt <= beat_cnt + OFFSET_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (last_beat) begin
            tag_mem[lat_index] <= lat_tag;
        end
    end

    dcache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk   (i_Clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wbe   (ram_wbe),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed plan steps plus randomized traffic
// against a line-level cache model and a backing-memory array.
`default_nettype none

module tb_dcache_controller;

    localparam int LINES = 16;
    localparam int WPL   = 4;

    logic        clk;
    logic        rst_n;
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        stall, rvalid;
    logic [31:0] rdata;
    logic        mreq, mwrite;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mbe;
    logic        mready, mrvalid;
    logic [31:0] mrdata;

    dcache_controller #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .i_Clock         (clk),
        .i_Reset         (rst_n),
        .i_Req           (req),
        .i_Write         (wr),
        .i_Addr          (addr),
        .i_WriteData     (wdata),
        .i_ByteEnable    (be),
        .o_Stall         (stall),
        .o_ReadValid     (rvalid),
        .o_ReadData      (rdata),
        .o_MemReq        (mreq),
        .o_MemWrite      (mwrite),
        .o_MemAddr       (maddr),
        .o_MemWriteData  (mwdata),
        .o_MemByteEnable (mbe),
        .i_MemReady      (mready),
        .i_MemReadValid  (mrvalid),
        .i_MemReadData   (mrdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Backing memory keyed by word address, plus a line-level cache model.
    logic [31:0] backing [int unsigned];
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];

    // Memory responder state.
    int          ready_delay, beat_gap, wait_cnt, gap_cnt, beat_idx;
    int          refills, writes, beats_sent;
    bit          refill_active;
    logic [31:0] refill_addr, wr_addr, wr_data;
    logic [3:0]  wr_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned w);
        if (backing.exists(w)) return backing[w];
        return (w * 32'h9E37_79B1) + 32'h0BAD_F00D;
    endfunction

    function automatic int unsigned l_idx(input logic [31:0] a);
        return (a / (WPL * 4)) % LINES;
    endfunction

    function automatic int unsigned l_tag(input logic [31:0] a);
        return a / (WPL * 4 * LINES);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Called at posedge+1: decides this cycle's memory-side inputs.
    task automatic mem_drive();
        mready  = 1'b0;
        mrvalid = 1'b0;
        mrdata  = $urandom;
        if (mreq) begin
            if (wait_cnt == ready_delay) begin
                mready   = 1'b1;
                wait_cnt = 0;
                if (mwrite) begin
                    writes++;
                    wr_addr = maddr;
                    wr_data = mwdata;
                    wr_be   = mbe;
                    backing[maddr >> 2] = merge(mem_rd(maddr >> 2), mwdata, mbe);
                end else begin
                    refills++;
                    refill_addr   = maddr;
                    refill_active = 1'b1;
                    beat_idx      = 0;
                    gap_cnt       = beat_gap;
                end
            end else begin
                wait_cnt++;
            end
        end else if (refill_active) begin
            if (gap_cnt == 0) begin
                mrvalid = 1'b1;
                mrdata  = mem_rd((refill_addr >> 2) + beat_idx);
                beat_idx++;
                beats_sent++;
                gap_cnt = beat_gap;
                if (beat_idx == WPL) refill_active = 1'b0;
            end else begin
                gap_cnt--;
            end
        end else begin
            // Stray handshakes that the cache must ignore.
            mready  = 1'($urandom_range(0, 1));
            mrvalid = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_rdata"},  rdata,       32'd0);
        check({tag, "_mreq"},   32'(mreq),   32'd0);
        check({tag, "_mwrite"}, 32'(mwrite), 32'd0);
        check({tag, "_maddr"},  maddr,       32'd0);
        check({tag, "_mwdata"}, mwdata,      32'd0);
        check({tag, "_mbe"},    32'(mbe),    32'd0);
        check({tag, "_stall"},  32'(stall),  32'(req));
    endtask

    // Entered and left at posedge+1. abort_beats>0 asserts reset after that many beats.
    task automatic run_req(input string tag, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] en,
                           input int dly, input int gap, input int abort_beats);
        int unsigned idx, tg;
        bit          exp_hit, done;
        int          stalls, exp_stalls;
        idx     = l_idx(a);
        tg      = l_tag(a);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        ready_delay = dly; beat_gap = gap; wait_cnt = 0;
        refills = 0; writes = 0; beats_sent = 0;
        req   = 1'b1;
        wr    = w;
        addr  = {a[31:2], 2'($urandom_range(0, 3))};
        wdata = d;
        be    = en;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            mem_drive();
            #1;
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
            if (abort_beats > 0 && beats_sent == abort_beats) begin
                rst_n = 1'b0;
                refill_active = 1'b0;
                mready = 1'b0; mrvalid = 1'b0;
                #1;
                check_reset_outputs({tag, "_abort"});
                req = 1'b0;
                #1;
                check({tag, "_abort_stall_idle"}, 32'(stall), 32'd0);
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (!w && !exp_hit) exp_stalls = 2 + dly + WPL * (gap + 1);
        else if (w)         exp_stalls = 1 + dly;
        else                exp_stalls = 0;
        check({tag, "_stalls"},  stalls,     exp_stalls);
        check({tag, "_refills"}, refills,    (!w && !exp_hit) ? 1 : 0);
        check({tag, "_beats"},   beats_sent, (!w && !exp_hit) ? WPL : 0);
        check({tag, "_writes"},  writes,     w ? 1 : 0);
        if (!w && !exp_hit) check({tag, "_refill_addr"}, refill_addr, a & ~32'(WPL * 4 - 1));
        if (w) begin
            check({tag, "_wr_addr"}, wr_addr, {a[31:2], 2'b00});
            check({tag, "_wr_data"}, wr_data, d);
            check({tag, "_wr_be"},   32'(wr_be), 32'(en));
        end
        if (!w && !exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        req   = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        mem_drive();
        #1;
        check({tag, "_rvalid"}, 32'(rvalid), w ? 32'd0 : 32'd1);
        if (!w) check({tag, "_rdata"}, rdata, mem_rd(a >> 2));
        check({tag, "_idle_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_drive();
        #1;
        check({tag, "_rvalid_after"}, 32'(rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] hit_addrs [3];
        logic [31:0] ra;
        int unsigned sel;
        clk = 1'b0; rst_n = 1'b0;
        req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
        mready = 1'b0; mrvalid = 1'b0; mrdata = '0;
        refill_active = 1'b0;
        for (int i = 0; i < LINES; i++) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
        for (int k = 0; k < WPL; k++) backing[(32'h1000 >> 2) + k] = 32'hA0 + k;

        #2;
        check_reset_outputs("reset");
        req = 1'b1;
        #1;
        check("reset_stall_req", 32'(stall), 32'd1);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req("cold_load",  1'b0, 32'h0000_1004, 32'h0, 4'h0, 2, 1, 0);
        check("cold_value", mem_rd(32'h1004 >> 2), 32'hA1);
        run_req("hit_load",   1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 0, 0);

        hit_addrs[0] = 32'h0000_1000;
        hit_addrs[1] = 32'h0000_1004;
        hit_addrs[2] = 32'h0000_100C;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; wr = 1'b0; addr = hit_addrs[i];
            mem_drive();
            #1;
            check("b2b_stall", 32'(stall), 32'd0);
            if (i > 0) begin
                check("b2b_rvalid", 32'(rvalid), 32'd1);
                check("b2b_rdata",  rdata, mem_rd(hit_addrs[i-1] >> 2));
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        #1;
        check("b2b_last_rvalid", 32'(rvalid), 32'd1);
        check("b2b_last_rdata",  rdata, mem_rd(hit_addrs[2] >> 2));
        @(posedge clk); #1;

        run_req("store_hit",  1'b1, 32'h0000_1008, 32'h0000_BEEF, 4'b0011, 3, 0, 0);
        run_req("reload",     1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 0, 0);
        check("reload_value", mem_rd(32'h1008 >> 2), 32'h0000_BEEF);

        run_req("store_miss", 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF, 1, 0, 0);
        run_req("load_2000",  1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 2, 0);

        run_req("conf_a",     1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 0, 0);
        run_req("conf_b",     1'b0, 32'h0001_1000, 32'h0, 4'h0, 1, 0, 0);
        run_req("conf_a2",    1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            ra  = (sel == 0) ? 32'h10 : (sel == 1) ? 32'h11 : 32'h312;
            ra  = ra << 8;
            sel = $urandom_range(0, 2);
            ra  = ra | (((sel == 0) ? 32'd0 : (sel == 1) ? 32'd1 : 32'd5) << 4);
            ra  = ra | (32'($urandom_range(0, WPL - 1)) << 2);
            run_req("rand", ($urandom_range(0, 9) < 4), ra, $urandom,
                    4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end

        run_req("abort",      1'b0, 32'h0000_3004, 32'h0, 4'h0, 1, 1, 2);
        run_req("after_abort", 1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
